// File: rtl/amo_ctrl_pkg.sv
// Shared AMO definitions: ALU control codes, AMO funct5 encodings, FSM states.
package amo_ctrl_pkg;

  localparam int ALU_CTRL_WIDTH = 4;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD_ADDI = 4'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_LUI      = 4'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR_XORI = 4'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND_ANDI = 4'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR_ORI   = 4'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MIN      = 4'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MAX      = 4'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MINU     = 4'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_MAXU     = 4'd8;

  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CALC,
    ST_WR,
    ST_FIN
  } amo_state_t;

endpackage

// File: rtl/amo_ctrl_decode.sv
// AMO funct5 decoder: selects the ALU operation and flags unsupported encodings.
module amo_decode
  import amo_ctrl_pkg::*;
(
  input  logic [4:0]                funct5,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic                      legal
);

  // Map funct5 to ALU control; LR/SC and anything unknown are illegal.
  always_comb begin
    alu_ctrl = ALU_CTRL_ADD_ADDI;
    legal    = 1'b1;
    case (funct5)
      AMO_SWAP: alu_ctrl = ALU_CTRL_LUI;
      AMO_ADD:  alu_ctrl = ALU_CTRL_ADD_ADDI;
      AMO_XOR:  alu_ctrl = ALU_CTRL_XOR_XORI;
      AMO_AND:  alu_ctrl = ALU_CTRL_AND_ANDI;
      AMO_OR:   alu_ctrl = ALU_CTRL_OR_ORI;
      AMO_MIN:  alu_ctrl = ALU_CTRL_MIN;
      AMO_MAX:  alu_ctrl = ALU_CTRL_MAX;
      AMO_MINU: alu_ctrl = ALU_CTRL_MINU;
      AMO_MAXU: alu_ctrl = ALU_CTRL_MAXU;
      default:  legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/amo_ctrl.sv
// AMO controller: read-modify-write of one aligned word through a shared ALU.
module amo_ctrl
  import amo_ctrl_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [4:0]                funct5,
  input  logic [31:0]               addr,
  input  logic [31:0]               rs2,
  output logic                      busy,
  output logic                      done,
  output logic                      illegal,
  output logic [31:0]               rd_data,
  output logic                      mem_valid,
  output logic                      mem_wr,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic [31:0]               mem_rdata,
  input  logic                      mem_ready,
  output logic [31:0]               alu_a,
  output logic [31:0]               alu_b,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [31:0]               alu_result
);

  amo_state_t                state, state_nxt;
  logic [31:0]               addr_q, rs2_q, wdata_q;
  logic [ALU_CTRL_WIDTH-1:0] ctrl_q, dec_ctrl;
  logic                      illegal_q, dec_legal, req_ok, accept;

  amo_decode u_decode (
    .funct5   (funct5),
    .alu_ctrl (dec_ctrl),
    .legal    (dec_legal)
  );

  assign req_ok = dec_legal && !(CHECK_ALIGN && (addr[1:0] != 2'b00));
  assign accept = (state == ST_IDLE) && start;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next state and state-decoded outputs; memory outputs depend only on state
  // and latched registers, so they hold steady across ready stalls.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    illegal   = 1'b0;
    mem_valid = 1'b0;
    mem_wr    = 1'b0;
    mem_wstrb = 4'b0000;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = req_ok ? ST_RD : ST_FIN;
      end
      ST_RD: begin
        mem_valid = 1'b1;
        if (mem_ready) state_nxt = ST_CALC;
      end
      ST_CALC: state_nxt = ST_WR;
      ST_WR: begin
        mem_valid = 1'b1;
        mem_wr    = 1'b1;
        mem_wstrb = 4'b1111;
        if (mem_ready) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        illegal   = illegal_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latches, read capture and ALU result capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      rs2_q     <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      rd_data   <= '0;
      wdata_q   <= '0;
    end else begin
      if (accept) begin
        addr_q    <= addr;
        rs2_q     <= rs2;
        ctrl_q    <= dec_ctrl;
        illegal_q <= !req_ok;
      end
      if (state == ST_RD && mem_ready) rd_data <= mem_rdata;
      if (state == ST_CALC)            wdata_q <= alu_result;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign alu_a     = rd_data;
  assign alu_b     = rs2_q;
  assign alu_ctrl  = ctrl_q;

endmodule

// File: tb/tb_amo_ctrl.sv
// Self-checking bench for amo_ctrl: directed cases, randomized ops, reset abort.
module tb_amo_ctrl;
  import amo_ctrl_pkg::*;

  logic                      clk = 1'b0;
  logic                      resetn = 1'b0;
  logic                      start = 1'b0;
  logic [4:0]                funct5 = '0;
  logic [31:0]               addr = '0, rs2 = '0;
  logic                      busy, done, illegal, mem_valid, mem_wr;
  logic [31:0]               rd_data, mem_addr, mem_wdata, alu_a, alu_b;
  logic [3:0]                mem_wstrb;
  logic [31:0]               mem_rdata = '0;
  logic                      mem_ready = 1'b0;
  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl;
  logic [31:0]               alu_result;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] prev_rd = '0;

  amo_ctrl #(.CHECK_ALIGN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .funct5(funct5), .addr(addr),
    .rs2(rs2), .busy(busy), .done(done), .illegal(illegal), .rd_data(rd_data),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // External ALU as the core would provide it (LUI passes operand b through).
  always_comb begin
    case (alu_ctrl)
      ALU_CTRL_ADD_ADDI: alu_result = alu_a + alu_b;
      ALU_CTRL_LUI:      alu_result = alu_b;
      ALU_CTRL_XOR_XORI: alu_result = alu_a ^ alu_b;
      ALU_CTRL_AND_ANDI: alu_result = alu_a & alu_b;
      ALU_CTRL_OR_ORI:   alu_result = alu_a | alu_b;
      ALU_CTRL_MIN:      alu_result = ($signed(alu_a) < $signed(alu_b)) ? alu_a : alu_b;
      ALU_CTRL_MAX:      alu_result = ($signed(alu_a) > $signed(alu_b)) ? alu_a : alu_b;
      ALU_CTRL_MINU:     alu_result = (alu_a < alu_b) ? alu_a : alu_b;
      ALU_CTRL_MAXU:     alu_result = (alu_a > alu_b) ? alu_a : alu_b;
      default:           alu_result = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: is the request legal, and what word does the AMO store.
  function automatic bit ref_legal(input logic [4:0] f, input logic [31:0] a);
    bit ok;
    ok = (f == 5'b00000) || (f == 5'b00001) || (f == 5'b00100) || (f == 5'b01100) ||
         (f == 5'b01000) || (f == 5'b10000) || (f == 5'b10100) || (f == 5'b11000) ||
         (f == 5'b11100);
    return ok && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] ref_store(input logic [4:0] f, input logic [31:0] m,
                                            input logic [31:0] b);
    int signed sm, sb;
    sm = m; sb = b;
    case (f)
      5'b00001: return b;
      5'b00000: return m + b;
      5'b00100: return m ^ b;
      5'b01100: return m & b;
      5'b01000: return m | b;
      5'b10000: return (sm <= sb) ? m : b;
      5'b10100: return (sm >= sb) ? m : b;
      5'b11000: return (m <= b) ? m : b;
      default:  return (m >= b) ? m : b;
    endcase
  endfunction

  // One AMO with rst/wst ready wait cycles; random start pulses while busy.
  task automatic run_op(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] mword, input int unsigned rst,
                        input int unsigned wst);
    bit          legal, seen_done, wrote, any_valid;
    logic [31:0] exp_w;
    int unsigned exp_lat, cyc, rwait, wwait, nwr;
    legal   = ref_legal(f, a);
    exp_w   = ref_store(f, mword, b);
    exp_lat = legal ? 4 + rst + wst : 1;
    seen_done = 0; wrote = 0; any_valid = 0;
    cyc = 0; rwait = 0; wwait = 0; nwr = 0;
    @(negedge clk);
    start = 1'b1; funct5 = f; addr = a; rs2 = b; mem_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; funct5 = 5'($urandom); addr = $urandom; rs2 = $urandom;
    while (!seen_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (mem_valid) any_valid = 1;
      if (done) begin
        seen_done = 1;
        chk("latency", cyc, exp_lat);
        chk("illegal", {31'b0, illegal}, {31'b0, !legal});
        chk("busy_fin", {31'b0, busy}, 32'd1);
        start = 1'b0;
        mem_ready = 1'($urandom);
      end else begin
        if (busy !== 1'b1) chk("busy_op", {31'b0, busy}, 32'd1);
        if (mem_valid && !mem_wr) begin
          chk("rd_addr", mem_addr, a);
          chk("rd_strb", {28'b0, mem_wstrb}, 32'h0);
          if (rwait < rst) begin mem_ready = 1'b0; mem_rdata = $urandom; rwait++; end
          else begin mem_ready = 1'b1; mem_rdata = mword; end
        end else if (mem_valid && mem_wr) begin
          chk("wr_addr", mem_addr, a);
          chk("wr_data", mem_wdata, exp_w);
          chk("wr_strb", {28'b0, mem_wstrb}, 32'hF);
          if (wwait < wst) begin mem_ready = 1'b0; wwait++; end
          else begin mem_ready = 1'b1; wrote = 1; nwr++; end
        end else begin
          mem_ready = 1'($urandom);
          mem_rdata = $urandom;
        end
        start = 1'($urandom); funct5 = 5'($urandom); addr = $urandom; rs2 = $urandom;
      end
    end
    chk("done_seen", {31'b0, seen_done}, 32'd1);
    chk("mem_used", {31'b0, any_valid}, {31'b0, legal});
    chk("writes", nwr, legal ? 32'd1 : 32'd0);
    if (legal) prev_rd = mword;
    @(negedge clk);
    chk("rd_data", rd_data, prev_rd);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_done", {31'b0, done}, 32'd0);
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [4:0]  ops [11];
    logic [31:0] r, ra;
    int unsigned cyc;
    ops = '{5'b00000, 5'b00001, 5'b00100, 5'b01100, 5'b01000, 5'b10000,
            5'b10100, 5'b11000, 5'b11100, 5'b00010, 5'b00011};

    // Reset state.
    #2;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, mem_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rd", rd_data, 32'h0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // Directed cases.
    run_op(5'b00000, 32'h0000_1000, 32'h0000_0003, 32'h0000_0005, 0, 0);
    run_op(5'b10000, 32'h0000_2000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0);
    run_op(5'b11000, 32'h0000_2000, 32'h0000_0001, 32'hFFFF_FFFF, 0, 0);
    run_op(5'b00001, 32'h0000_3000, 32'hCAFE_BABE, 32'h1234_5678, 3, 2);
    run_op(5'b00010, 32'h0000_1000, 32'h1111_1111, 32'h2222_2222, 0, 0);
    run_op(5'b00000, 32'h0000_1002, 32'h1111_1111, 32'h2222_2222, 0, 0);

    // Randomized ops.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      r  = $urandom;
      if (r[3:0] != 4'd0) ra[1:0] = 2'b00;
      run_op((r[7:4] == 4'd0) ? 5'($urandom) : ops[$urandom_range(0, 10)],
             ra, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset during a stalled write.
    @(negedge clk);
    start = 1'b1; funct5 = 5'b00000; addr = 32'h40; rs2 = 32'h1; mem_rdata = 32'h7;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(mem_valid && mem_wr) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      mem_ready = !(mem_valid && mem_wr);
    end
    chk("wr_reached", {31'b0, mem_valid && mem_wr}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("abort_valid", {31'b0, mem_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_rd", rd_data, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_valid", {31'b0, mem_valid}, 32'd0);
    end
    mem_ready = 1'b0;
    prev_rd = '0;
    run_op(5'b01000, 32'h0000_0080, 32'h0F0F_0000, 32'h0000_F0F0, 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/amo_ctrl.md
AMO_CTRL -- requirements
Module: amo_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CHECK_ALIGN, 1, flag misaligned addr as illegal when 1.
REQ-002 Clock and reset SHALL be one clock `clk` and reset `resetn`; reset is asynchronous and active-low.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- resetn  in  1  async active-low reset
- start  in  1  AMO request, one-cycle pulse from main FSM
- funct5  in  5  AMO funct5 field
- addr  in  32  rs1 address
- rs2  in  32  rs2 operand
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle pulse with done on unsupported funct5 or misalignment
- rd_data  out  32  original memory word (rd writeback)
- mem_valid  out  1  memory request
- mem_wr  out  1  1=write, 0=read
- mem_addr  out  32  request address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes
- mem_rdata  in  32  read data
- mem_ready  in  1  memory accept/complete
- alu_a  out  32  ALU operand a
- alu_b  out  32  ALU operand b
- alu_ctrl  out  `ALU_CTRL_WIDTH  ALU operation select
- alu_result  in  32  ALU result

Function
REQ-004 States SHALL be IDLE, RD, CALC, WR, FIN.
REQ-005 IDLE: start=1 with legal request SHALL go to RD; with illegal request SHALL go to FIN with illegal set, no memory access.
REQ-006 start SHALL be ignored when busy=1.
REQ-007 RD: mem_valid=1, mem_wr=0, mem_wstrb=0000, mem_addr=latched addr; on mem_ready, rd_data<=mem_rdata, go to CALC.
REQ-008 CALC (exactly 1 cycle): alu_a=rd_data, alu_b=latched rs2, alu_ctrl per REQ-011; wdata register<=alu_result; go to WR.
REQ-009 WR: mem_valid=1, mem_wr=1, mem_wstrb=1111, mem_wdata=latched result; on mem_ready go to FIN.
REQ-010 FIN: done=1 one cycle, illegal as latched; next state IDLE.
REQ-011 funct5 mapping: 00001 SWAP->ALU_CTRL_LUI; 00000 ADD->ALU_CTRL_ADD_ADDI; 00100 XOR->ALU_CTRL_XOR_XORI; 01100 AND->ALU_CTRL_AND_ANDI; 01000 OR->ALU_CTRL_OR_ORI; 10000->ALU_CTRL_MIN; 10100->ALU_CTRL_MAX; 11000->ALU_CTRL_MINU; 11100->ALU_CTRL_MAXU; all others (incl. LR 00010, SC 00011) illegal.
REQ-012 Misaligned (addr[1:0]!=0) SHALL be illegal when CHECK_ALIGN=1, ignored when 0.
REQ-013 funct5, addr, rs2 SHALL be latched on accepted start; later input changes have no effect.
REQ-014 mem_valid, mem_addr, mem_wr, mem_wdata, mem_wstrb SHALL stay stable until the cycle mem_ready=1; handshake completes on the edge where valid&ready.
REQ-015 mem_ready outside RD/WR SHALL be ignored.
REQ-016 busy SHALL be 1 in RD, CALC, WR, FIN; 0 in IDLE.
REQ-017 Zero-wait memory latency: start at edge N -> done high in cycle N+4; each mem_ready wait cycle adds 1.
REQ-018 alu_a/alu_b/alu_ctrl outside CALC SHALL hold CALC-state values (no glitch requirement on ALU).
REQ-019 rd_data SHALL hold until the next accepted read; illegal requests leave it unchanged.

Reset
REQ-020 resetn=0 SHALL asynchronously force IDLE, busy=0, done=0, illegal=0, mem_valid=0, mem_wr=0, mem_wstrb=0, rd_data=0, all latches 0.
REQ-021 Reset mid-operation SHALL drop mem_valid immediately; no write issued after release.

Structure
REQ-022 AMO funct5 constants and state encodings SHALL live in riscv_defines.vh alongside ALU_CTRL_* codes.
REQ-023 One combinational sub-module amo_decode (funct5 -> alu_ctrl, legal) SHALL be used.

Verification
REQ-024 AMOADD, mem word 0x00000005, rs2 0x00000003, ready always 1 -> done at N+4, rd_data=0x00000005, write 0x00000008 wstrb 1111.
REQ-025 AMOMIN, mem 0xFFFFFFFF, rs2 0x00000001 -> write 0xFFFFFFFF; AMOMINU same data -> write 0x00000001.
REQ-026 AMOSWAP, mem 0x12345678, rs2 0xCAFEBABE, ready stalled 3 cycles on read and 2 on write -> outputs stable throughout, done at N+9, write 0xCAFEBABE.
REQ-027 funct5=00010 or addr=0x1002 -> done+illegal at N+1, mem_valid never asserted.
REQ-028 resetn low during WR wait -> mem_valid 0 same cycle, state IDLE; start asserted while busy -> ignored.
